// File: rtl/bird_physics_if.sv
// Bird physics bus: game-state FSM / pipe generator drive the controls,
// the physics engine returns the bird's vertical state and collision flags.
//   state    : game state (0 READY, 1 PLAY, 2 FALL, 3 HOLD)
//   flap_btn : raw asynchronous flap button
//   pipe_x   : pipe right-edge X per slot, slot i at [10i+9:10i]
//   pipe_y   : pipe gap top Y per slot, slot i at [9i+8:9i]
//   v_pos    : bird bottom Y
//   vel      : velocity magnitude
//   vel_up   : 1 = moving up
//   hit_pipe : per-slot collision flag
//   landed   : bird resting on the ground line
//   is_dead  : sticky death flag
interface bird_physics_if #(
  parameter int unsigned Y_W    = 9,
  parameter int unsigned V_W    = 6,
  parameter int unsigned PIPE_N = 2
) ();

  logic [1:0]           state;
  logic                 flap_btn;
  logic [10*PIPE_N-1:0] pipe_x;
  logic [9*PIPE_N-1:0]  pipe_y;
  logic [Y_W-1:0]       v_pos;
  logic [V_W-1:0]       vel;
  logic                 vel_up;
  logic [PIPE_N-1:0]    hit_pipe;
  logic                 landed;
  logic                 is_dead;

  modport master (
    output state, flap_btn, pipe_x, pipe_y,
    input  v_pos, vel, vel_up, hit_pipe, landed, is_dead
  );

  modport slave (
    input  state, flap_btn, pipe_x, pipe_y,
    output v_pos, vel, vel_up, hit_pipe, landed, is_dead
  );

endinterface

// File: rtl/bird_physics.sv
// Vertical-motion and collision engine for the player bird, clocked on the
// millisecond tick. Integrates gravity and flap impulses into velocity and
// position, checks the bird box against PIPE_N pipe slots and the ground,
// and keeps a sticky death flag.
// Ports:
//   clk_ms : millisecond tick clock
//   rst_n  : asynchronous active-low reset
//   bus    : bird_physics_if slave (controls in, bird state / flags out)
module bird_physics #(
  parameter int unsigned Y_W     = 9,
  parameter int unsigned V_W     = 6,
  parameter int unsigned PIPE_N  = 2,
  parameter int unsigned FLAP_V  = 30,
  parameter int unsigned GRAVITY = 3,
  parameter int unsigned V_MAX   = 45,
  parameter int unsigned H_POS   = 320,
  parameter int unsigned SLOT_W  = 60,
  parameter int unsigned SLOT_H  = 100,
  parameter int unsigned LAND_H  = 100,
  parameter int unsigned Y_TOP   = 455,
  parameter int unsigned BIRD_W  = 34,
  parameter int unsigned BIRD_H  = 24,
  parameter int unsigned Y_START = 240
) (
  input  logic           clk_ms,
  input  logic           rst_n,
  bird_physics_if.slave  bus
);

  // Position math one bit wider so up/down steps cannot wrap.
  localparam int unsigned P_W = Y_W + 1;
  // Signed collision math with headroom for x<SLOT_W / y<SLOT_H.
  localparam int unsigned C_W = Y_W + 3;

  localparam logic signed [C_W-1:0] K_X_HI  = C_W'(H_POS - 2);
  localparam logic signed [C_W-1:0] K_SW_M1 = C_W'(SLOT_W - 1);
  localparam logic signed [C_W-1:0] K_X_LO  = C_W'(H_POS - BIRD_W + 4);
  localparam logic signed [C_W-1:0] K_BH_M2 = C_W'(BIRD_H - 2);
  localparam logic signed [C_W-1:0] K_TWO   = C_W'(2);
  localparam logic signed [C_W-1:0] K_SH    = C_W'(SLOT_H);

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_FALL  = 2'd2,
    ST_HOLD  = 2'd3
  } game_state_e;

  game_state_e w_state;
  assign w_state = game_state_e'(bus.state);

  // Flap path: two-flop synchroniser followed by a rising-edge detector.
  logic r_sync1;
  logic r_sync2;
  logic r_flap_prev;
  logic w_flap_ev;

  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_flap_prev <= 1'b0;
    end else begin
      r_sync1     <= bus.flap_btn;
      r_sync2     <= r_sync1;
      r_flap_prev <= r_sync2;
    end
  end

  assign w_flap_ev = r_sync2 & ~r_flap_prev;

  // Bird state registers and their next values.
  logic [Y_W-1:0]    r_v_pos;
  logic [V_W-1:0]    r_vel;
  logic              r_vel_up;
  logic [PIPE_N-1:0] r_hit;
  logic              r_dead;

  logic [Y_W-1:0]    w_pos_nxt;
  logic [V_W-1:0]    w_vel_nxt;
  logic              w_up_nxt;
  logic [PIPE_N-1:0] w_hit_nxt;
  logic              w_dead_nxt;

  // Per-slot collision against the registered position and live pipe inputs.
  logic [PIPE_N-1:0]      w_hit;
  logic signed [C_W-1:0]  w_cv;
  logic signed [C_W-1:0]  w_cx;
  logic signed [C_W-1:0]  w_cy;

  always_comb begin
    w_hit = '0;
    w_cv  = signed'(C_W'(r_v_pos));
    w_cx  = '0;
    w_cy  = '0;
    for (int i = 0; i < int'(PIPE_N); i++) begin
      w_cx = signed'(C_W'(bus.pipe_x[10*i +: 10]));
      w_cy = signed'(C_W'(bus.pipe_y[9*i +: 9]));
      w_hit[i] = (K_X_HI > w_cx - K_SW_M1) &&
                 (K_X_LO < w_cx) &&
                 ((w_cv + K_BH_M2 > w_cy) || (w_cv + K_TWO < w_cy - K_SH));
    end
  end

  // Next-state: velocity first, then position from the new velocity.
  logic [V_W-1:0] w_vacc;
  logic [P_W-1:0] w_sum;
  logic [P_W-1:0] w_floor;
  logic           w_move;

  always_comb begin
    w_pos_nxt  = r_v_pos;
    w_vel_nxt  = r_vel;
    w_up_nxt   = r_vel_up;
    w_hit_nxt  = r_hit;
    w_dead_nxt = r_dead;
    w_vacc     = '0;
    w_sum      = '0;
    w_floor    = '0;
    w_move     = 1'b0;

    unique case (w_state)
      ST_READY: begin
        w_pos_nxt  = Y_W'(Y_START);
        w_vel_nxt  = '0;
        w_up_nxt   = 1'b0;
        w_hit_nxt  = '0;
        w_dead_nxt = 1'b0;
      end
      ST_PLAY: begin
        w_move = 1'b1;
        w_vacc = r_vel + V_W'(GRAVITY);
        if (w_flap_ev) begin
          w_vel_nxt = V_W'(FLAP_V);
          w_up_nxt  = 1'b1;
        end else if (r_vel_up && (r_vel <= V_W'(GRAVITY))) begin
          w_vel_nxt = '0;
          w_up_nxt  = 1'b0;
        end else if (r_vel_up) begin
          w_vel_nxt = r_vel - V_W'(GRAVITY);
        end else begin
          w_vel_nxt = (w_vacc > V_W'(V_MAX)) ? V_W'(V_MAX) : w_vacc;
        end
      end
      ST_FALL: begin
        // Falling from an upward move stalls first, then doubles gravity.
        w_move   = 1'b1;
        w_up_nxt = 1'b0;
        w_vacc   = r_vel + V_W'(2 * GRAVITY);
        if (r_vel_up) begin
          w_vel_nxt = '0;
        end else begin
          w_vel_nxt = (w_vacc > V_W'(V_MAX)) ? V_W'(V_MAX) : w_vacc;
        end
      end
      ST_HOLD: begin
      end
      default: begin
      end
    endcase

    if (w_move) begin
      w_sum   = P_W'(r_v_pos) + P_W'(w_vel_nxt);
      w_floor = P_W'(LAND_H) + P_W'(w_vel_nxt);
      if (w_up_nxt) begin
        w_pos_nxt = (w_sum > P_W'(Y_TOP)) ? Y_W'(Y_TOP) : w_sum[Y_W-1:0];
      end else begin
        w_pos_nxt = (P_W'(r_v_pos) < w_floor) ? Y_W'(LAND_H - 1)
                                              : r_v_pos - Y_W'(w_vel_nxt);
      end
      w_hit_nxt  = w_hit;
      w_dead_nxt = r_dead | (|w_hit) | (r_v_pos < Y_W'(LAND_H));
    end
  end

  // Bird state register.
  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      r_v_pos  <= Y_W'(Y_START);
      r_vel    <= '0;
      r_vel_up <= 1'b0;
      r_hit    <= '0;
      r_dead   <= 1'b0;
    end else begin
      r_v_pos  <= w_pos_nxt;
      r_vel    <= w_vel_nxt;
      r_vel_up <= w_up_nxt;
      r_hit    <= w_hit_nxt;
      r_dead   <= w_dead_nxt;
    end
  end

  assign bus.v_pos    = r_v_pos;
  assign bus.vel      = r_vel;
  assign bus.vel_up   = r_vel_up;
  assign bus.hit_pipe = r_hit;
  assign bus.is_dead  = r_dead;
  // Ground contact decoded straight from the registered position.
  assign bus.landed   = (r_v_pos == Y_W'(LAND_H - 1));

endmodule

// File: tb/tb_bird_physics.sv
// Scoreboard bench for bird_physics: a driver issues one tick of stimulus at a
// time and pushes the reference model's expected outputs; a monitor pops and
// compares on every falling edge.
module tb_bird_physics;

  localparam int Y_START = 240;
  localparam int FLAP_V  = 30;
  localparam int GRAVITY = 3;
  localparam int V_MAX   = 45;
  localparam int H_POS   = 320;
  localparam int SLOT_W  = 60;
  localparam int SLOT_H  = 100;
  localparam int LAND_H  = 100;
  localparam int Y_TOP   = 455;
  localparam int BIRD_W  = 34;
  localparam int BIRD_H  = 24;

  typedef struct packed {
    logic [8:0] v;
    logic [5:0] vel;
    logic       up;
    logic [1:0] hit;
    logic       landed;
    logic       dead;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bird_physics_if #(.Y_W(9), .V_W(6), .PIPE_N(2)) bus ();

  bird_physics dut (
    .clk_ms (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state.
  int   m_v, m_vel;
  bit   m_up, m_dead;
  bit [1:0] m_hit;
  bit   bh[$];
  int   px[2];
  int   py[2];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit coll(int x, int y, int v);
    return (H_POS - 2 > x - SLOT_W + 1) && (H_POS - BIRD_W + 4 < x) &&
           ((v + BIRD_H - 2 > y) || (v + 2 < y - SLOT_H));
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_v = Y_START; m_vel = 0; m_up = 0; m_hit = 0; m_dead = 0;
    bh.delete();
    repeat (3) bh.push_back(1'b0);
  endtask

  // One tick of game physics from the behavioural rules.
  task automatic model_step(int st, bit btn);
    bit flap;
    bit [1:0] h;
    flap = bh[$-1] && !bh[$-2];
    for (int i = 0; i < 2; i++) h[i] = coll(px[i], py[i], m_v);
    case (st)
      0: begin
        m_v = Y_START; m_vel = 0; m_up = 0; m_hit = 0; m_dead = 0;
      end
      1, 2: begin
        if (st == 1) begin
          if (flap) begin m_vel = FLAP_V; m_up = 1; end
          else if (m_up && m_vel <= GRAVITY) begin m_vel = 0; m_up = 0; end
          else if (m_up) m_vel = m_vel - GRAVITY;
          else m_vel = imin(m_vel + GRAVITY, V_MAX);
        end else begin
          m_vel = m_up ? 0 : imin(m_vel + 2 * GRAVITY, V_MAX);
          m_up  = 0;
        end
        m_dead = m_dead || (h != 0) || (m_v < LAND_H);
        m_hit  = h;
        if (m_up) m_v = imin(m_v + m_vel, Y_TOP);
        else      m_v = (m_v < LAND_H + m_vel) ? LAND_H - 1 : m_v - m_vel;
      end
      default: ;
    endcase
    bh.push_back(btn);
    if (bh.size() > 8) void'(bh.pop_front());
  endtask

  task automatic push_exp();
    exp_t e;
    e.v = 9'(m_v); e.vel = 6'(m_vel); e.up = m_up; e.hit = m_hit;
    e.landed = (m_v == LAND_H - 1); e.dead = m_dead;
    q.push_back(e);
  endtask

  // Drive one tick of stimulus mid-cycle and queue the expected response.
  task automatic tick(bit rst, int st, bit btn);
    bit falling;
    @(negedge clk);
    #2;
    falling = rst_n && !rst;
    rst_n        = rst;
    bus.state    = 2'(st);
    bus.flap_btn = btn;
    bus.pipe_x   = {10'(px[1]), 10'(px[0])};
    bus.pipe_y   = {9'(py[1]), 9'(py[0])};
    if (falling) begin
      #1;
      chk("async_rst_v_pos", int'(bus.v_pos), Y_START);
      chk("async_rst_vel", int'(bus.vel), 0);
      chk("async_rst_vel_up", int'(bus.vel_up), 0);
      chk("async_rst_hit", int'(bus.hit_pipe), 0);
      chk("async_rst_dead", int'(bus.is_dead), 0);
      chk("async_rst_landed", int'(bus.landed), 0);
    end
    if (!rst) model_reset();
    else model_step(st, btn);
    push_exp();
  endtask

  // Monitor: compare the DUT against the oldest expectation every tick.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("v_pos", int'(bus.v_pos), int'(e.v));
        chk("vel", int'(bus.vel), int'(e.vel));
        chk("vel_up", int'(bus.vel_up), int'(e.up));
        chk("hit_pipe", int'(bus.hit_pipe), int'(e.hit));
        chk("landed", int'(bus.landed), int'(e.landed));
        chk("is_dead", int'(bus.is_dead), int'(e.dead));
      end
    end
  end

  initial begin
    bit b;
    int r, st;
    bus.state = 2'd0; bus.flap_btn = 1'b0; bus.pipe_x = '0; bus.pipe_y = '0;
    px[0] = 1000; px[1] = 1000; py[0] = 300; py[1] = 300;
    model_reset();

    repeat (3) tick(0, 0, 0);
    repeat (3) tick(1, 0, 0);
    // Free fall to the ground, then FALL keeps it parked.
    repeat (25) tick(1, 1, 0);
    repeat (4) tick(1, 2, 0);
    // Held button gives a single impulse.
    repeat (2) tick(1, 0, 0);
    repeat (50) tick(1, 1, 1);
    repeat (5) tick(1, 1, 0);
    // Pipe slot 0 then slot 1.
    repeat (2) tick(1, 0, 0);
    px[0] = 340; py[0] = 300;
    tick(1, 1, 0);
    py[0] = 250;
    repeat (3) tick(1, 1, 0);
    px[0] = 1000; py[0] = 300;
    repeat (2) tick(1, 0, 0);
    px[1] = 340; py[1] = 300;
    tick(1, 1, 0);
    py[1] = 250;
    repeat (3) tick(1, 1, 0);
    // Repeated flaps against the ceiling with pipes at the far left.
    px[0] = 10; px[1] = 10; py[0] = 300; py[1] = 300;
    repeat (2) tick(1, 0, 0);
    repeat (30) begin
      tick(1, 1, 1); tick(1, 1, 1); tick(1, 1, 0); tick(1, 1, 0);
    end
    repeat (12) tick(1, 2, 0);
    repeat (3) tick(1, 3, 0);
    // Asynchronous reset in the middle of a dead fall, then restart.
    px[0] = 1000; px[1] = 1000;
    tick(1, 0, 0);
    repeat (12) tick(1, 1, 0);
    tick(1, 2, 0);
    tick(0, 2, 0);
    tick(0, 2, 0);
    tick(1, 0, 0);
    repeat (4) tick(1, 1, 0);
    // Randomised play.
    b = 0;
    repeat (700) begin
      if ($urandom_range(0, 99) < 30) b = ~b;
      r = $urandom_range(0, 99);
      st = (r < 3) ? 0 : (r < 85) ? 1 : (r < 95) ? 2 : 3;
      for (int i = 0; i < 2; i++) begin
        px[i] = ($urandom_range(0, 99) < 70) ? $urandom_range(250, 420) : $urandom_range(0, 1023);
        py[i] = $urandom_range(0, 511);
      end
      tick(($urandom_range(0, 199) != 0), st, b);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
